// File: rtl/aes_pkg.sv
// aes_pkg -- shared definitions for the AES inverse-cipher round controller.
//
// Contents:
//   state_t   : controller FSM state encoding (IDLE, ROUND, FINAL, DONE)
//   NR_AES128 : number of rounds for AES-128
//   INV_SBOX  : inverse S-box lookup table
//   inv_sbox  : byte lookup into INV_SBOX
package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round -- combinational AES inverse-cipher round.
//
// Computes next = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk),
// or, when last=1, next = InvSubBytes(InvShiftRows(state)) ^ rk.
//
// Block layout: byte i (row i%4, column i/4) sits in bits [127-8*i -: 8],
// so byte 0 is the most-significant byte of the vector.
//
// Ports:
//   state [127:0] in  : current cipher state
//   rk    [127:0] in  : round key for this round
//   last          in  : 1 = final round (no InvMixColumns)
//   next  [127:0] out : resulting state
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    logic [7:0] sk [16];

    always_comb begin
        sk   = '{default: 8'h00};
        next = '0;
        // InvShiftRows rotates row r right by r: output (r,c) takes input (r,c-r).
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sk[r + 4*c] = inv_sbox(state[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8])
                              ^ rk[127 - 8*(r + 4*c) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                next[127 - 8*(4*c)     -: 8] = sk[4*c];
                next[127 - 8*(4*c + 1) -: 8] = sk[4*c + 1];
                next[127 - 8*(4*c + 2) -: 8] = sk[4*c + 2];
                next[127 - 8*(4*c + 3) -: 8] = sk[4*c + 3];
            end else begin
                next[127 - 8*(4*c)     -: 8] = mule(sk[4*c]) ^ mulb(sk[4*c+1]) ^ muld(sk[4*c+2]) ^ mul9(sk[4*c+3]);
                next[127 - 8*(4*c + 1) -: 8] = mul9(sk[4*c]) ^ mule(sk[4*c+1]) ^ mulb(sk[4*c+2]) ^ muld(sk[4*c+3]);
                next[127 - 8*(4*c + 2) -: 8] = muld(sk[4*c]) ^ mul9(sk[4*c+1]) ^ mule(sk[4*c+2]) ^ mulb(sk[4*c+3]);
                next[127 - 8*(4*c + 3) -: 8] = mulb(sk[4*c]) ^ muld(sk[4*c+1]) ^ mul9(sk[4*c+2]) ^ mule(sk[4*c+3]);
            end
        end
    end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl -- iterative AES inverse cipher, one round per cycle.
//
// Round keys are fetched from an external key store: rk_idx selects the key,
// rk_data returns it combinationally in the same cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE, and
// out_block is held until the consumer raises out_ready.
//
// Block layout: byte 0 is the most-significant byte (bits 127:120),
// bytes ordered column-major.
//
// Optional feature: define AES_INV_ABORT_EN to add the abort input, which
// returns the block to IDLE from any busy state and discards the result.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : ciphertext handshake, in_block carries it
//   rk_idx, rk_data       : round-key request / returned key
//   out_valid/out_ready   : plaintext handshake, out_block carries it
//   abort                 : (AES_INV_ABORT_EN only) cancel current block
//   dbg_state             : current FSM state
module aes_inv_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
`ifdef AES_INV_ABORT_EN
    input  logic         abort,
`endif
    output state_t       dbg_state
);

    localparam logic [3:0] NR_IDX    = 4'(NR);
    localparam logic [3:0] NR_M1_IDX = 4'(NR - 1);

    state_t       fsm_q, fsm_d;
    logic [3:0]   r_q, r_d;
    logic [127:0] data_q, data_d;
    logic [127:0] round_next;
    logic         round_last;

    aes_inv_round u_round (
        .state (data_q),
        .rk    (rk_data),
        .last  (round_last),
        .next  (round_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q  <= ST_IDLE;
            r_q    <= '0;
            data_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            r_q    <= r_d;
            data_q <= data_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d  = fsm_q;
        r_d    = r_q;
        data_d = data_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Initial AddRoundKey with key NR happens on acceptance.
                    data_d = in_block ^ rk_data;
                    r_d    = NR_M1_IDX;
                    fsm_d  = (NR == 1) ? ST_FINAL : ST_ROUND;
                end
            end
            ST_ROUND: begin
                data_d = round_next;
                r_d    = r_q - 4'd1;
                if (r_q == 4'd1) begin
                    fsm_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                data_d = round_next;
                fsm_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
`ifdef AES_INV_ABORT_EN
        // Abort wins over every other transition, including the DONE handoff.
        if (abort && (fsm_q != ST_IDLE)) begin
            fsm_d  = ST_IDLE;
            r_d    = '0;
            data_d = '0;
        end
`endif
    end

    // Output logic
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_block  = '0;
        round_last = 1'b0;
        rk_idx     = NR_IDX;
        dbg_state  = fsm_q;
        unique case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                rk_idx   = NR_IDX;
            end
            ST_ROUND: begin
                rk_idx = r_q;
            end
            ST_FINAL: begin
                rk_idx     = 4'd0;
                round_last = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // Only the finished plaintext ever reaches out_block.
                out_block = data_q;
                rk_idx    = NR_IDX;
            end
            default: rk_idx = NR_IDX;
        endcase
    end

endmodule
